// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free ratio change and start/stop.
// Define CLK_DIV_ODD50_EN to enable the negedge helper flop that gives 50% duty for odd ratios.
`timescale 1ns/1ps
module clk_div_prog #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 3
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_ratio,
  output logic             clkout,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] ratio_cur
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] RATIO_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_RATIO = CNT_W'(2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] load_val;
  logic             at_end;
  logic             apply;
  logic             pos_q;
  logic             neg_q;

  always_comb begin
    load_val = (div_ratio < MIN_RATIO) ? MIN_RATIO : div_ratio;
    at_end   = (cnt == ratio_cur - ONE);
    cnt_nxt  = at_end ? '0 : cnt + ONE;
    half     = ratio_cur >> 1;
    // a pending ratio may only take effect where a new period can begin
    apply    = (state == IDLE) || at_end;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pos_q     <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      pending   <= RATIO_RST;
      ratio_cur <= RATIO_RST;
    end else begin
      if (load)
        pending <= load_val;
      if (apply && busy)
        ratio_cur <= pending;
      busy <= load | (busy & ~apply);

      case (state)
        IDLE: begin
          cnt   <= '0;
          pos_q <= en;
          tick  <= en;
          if (en)
            state <= RUN;
        end
        RUN: begin
          if (at_end) begin
            cnt   <= '0;
            pos_q <= en;
            tick  <= en;
            if (!en)
              state <= IDLE;
          end else begin
            cnt   <= cnt_nxt;
            pos_q <= (cnt_nxt < half);
            tick  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          pos_q <= 1'b0;
          tick  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_DIV_ODD50_EN
  // stretches the high phase by half a clkin cycle for odd ratios only
  always_ff @(negedge clkin or negedge rst_n) begin
    if (!rst_n)
      neg_q <= 1'b0;
    else
      neg_q <= pos_q & ratio_cur[0];
  end
`else
  assign neg_q = 1'b0;
`endif

  assign clkout = pos_q | neg_q;

endmodule
